imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage of the RISC-V core. It covers all RV32I/RV64I immediate formats (I, S, B, U, J), with an optional shift-amount mode and an illegal-opcode flag. It sits between fetch and decode behind a 2-entry valid/ready elastic buffer (1-cycle latency, full throughput, registered in_ready). A saturating counter tracks illegal opcodes for debug.

Parameters:
XLEN, 32, datapath width of out_imm; legal values 32 or 64.
TAG_W, 32, width of the sideband tag carried alongside each instruction (normally the PC).
SHAMT_MODE, 1, 1 = OP-IMM shifts yield a zero-extended shamt with fmt SHAMT; 0 = treat them as plain I-type.
CNT_W, 16, width of the illegal-opcode counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous pipeline clear.
in_valid  in  1  upstream has an instruction.
in_ready  out  1  block can accept; registered.
in_instr  in  32  instruction word.
in_tag  in  TAG_W  sideband tag, passed through unchanged.
out_valid  out  1  output record valid.
out_ready  in  1  downstream accepts.
out_imm  out  XLEN  generated immediate.
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
out_illegal  out  1  opcode not recognised.
out_tag  out  TAG_W  tag of the output record.
illegal_cnt  out  CNT_W  count of accepted illegal records, saturating.

Behaviour:
- Decode (combinational on in_instr, registered on acceptance). "sext" means sign-extend to XLEN.
  - I-type, opcodes 0010011, 0000011, 1100111: sext(instr[31:20]).
  - 0011011 (OP-IMM-32): I-type only when XLEN=64; illegal when XLEN=32.
  - S-type, 0100011: sext({instr[31:25], instr[11:7]}).
  - B-type, 1100011: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-type, 0110111 and 0010111: sext({instr[31:12], 12'b0}).
  - J-type, 1101111: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - SHAMT: SHAMT_MODE=1, opcode 0010011, funct3 001 or 101. Immediate is the zero-extended shamt: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64. For 0011011 it is always instr[24:20].
  - Any other opcode: imm=0, fmt=0, illegal=1.
- Buffer: main register M and skid register K. State is EMPTY, ONE or TWO.
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - out_valid = (state != EMPTY); outputs always driven from M.
  - in_ready = (state != TWO), registered, so it depends on no input in the same cycle.
- Transitions:
  - EMPTY: in_fire -> M <= new, go to ONE.
  - ONE: in_fire & out_fire -> M <= new, stay ONE. in_fire only -> K <= new, go to TWO. out_fire only -> EMPTY.
  - TWO: out_fire -> M <= K, go to ONE; otherwise hold.
- Latency: a record accepted in cycle N appears on the outputs in N+1. Order is strictly FIFO.
- Stability: while out_valid & ~out_ready, all out_* hold constant.
- flush: next state EMPTY and in_ready=1. A same-cycle in_fire is discarded and does not count toward illegal_cnt. M and K data may keep stale values.
- rst: highest priority, overriding flush.
  - State EMPTY, in_ready=1.
  - out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, K cleared, illegal_cnt=0.
  - Any in-flight records are lost.
- illegal_cnt: +1 on each in_fire whose decode is illegal; saturates at all-ones. Cleared only by rst, not by flush.
- No combinational path from in_* or out_ready to any output.

Test Plan:
1. XLEN=32, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0. Then 0xFE000EE3 (beq -4) -> 0xFFFFFFFC, fmt=3.
2. out_ready=0, offer A=0x123450B7, B=0x00309093, C in consecutive cycles:
   - A and B are accepted; in_ready=0 from the cycle after B is accepted; C is held.
   - out_imm stays 0x12345000 (fmt 4).
   - Raise out_ready: A, B and C emerge in order with no bubble.
3. SHAMT_MODE=1: 0x00309093 (slli 3) -> imm=3, fmt=6; 0x4030D093 (srai 3) -> imm=3, fmt=6. SHAMT_MODE=0: srai -> imm=0x403, fmt=1.
4. XLEN=64:
   - 0x800000B7 (lui 0x80000) -> 0xFFFFFFFF80000000, fmt=4.
   - 0xFF9FF06F (jal -8) -> 0xFFFFFFFFFFFFFFF8, fmt=5.
   - Opcode 0011011 -> legal, fmt=1. The same opcode at XLEN=32 -> illegal=1.
5. in_instr=0x0000007F accepted 3 times -> out_illegal=1, imm=0, illegal_cnt=3. With CNT_W=2, a 4th and 5th illegal leave the count at 3.
6. Fill to TWO, then assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged. Assert rst with state ONE -> all outputs 0 and illegal_cnt=0 next cycle.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Immediate generator for the decode stage. Each instruction word is decoded
// combinationally into an immediate, a format code and an illegal-opcode flag.
// The result is registered behind a two-entry valid/ready elastic buffer: main
// register M drives the outputs and skid register K absorbs one extra record.
// The result is one-cycle latency at full throughput, with in_ready registered.
//
// Parameters
//   XLEN       datapath width of out_imm (32 or 64)
//   TAG_W      width of the sideband tag (normally the PC)
//   SHAMT_MODE 1: OP-IMM shifts produce a zero-extended shamt, fmt SHAMT
//              0: OP-IMM shifts are treated as plain I-type
//   CNT_W      width of the saturating illegal-opcode counter
//
// Ports
//   clk, rst          clock, synchronous active-high reset (wins over flush)
//   flush             synchronous clear of the buffer; a same-cycle accept is dropped
//   in_valid/in_ready upstream handshake (in_ready is a register)
//   in_instr, in_tag  instruction word and its tag
//   out_valid/out_ready downstream handshake
//   out_imm, out_fmt, out_illegal, out_tag  record held in M
//   illegal_cnt       number of accepted illegal records, saturating
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 32,
  parameter int SHAMT_MODE = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } rec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               is_shift;
  logic signed [31:0] dec_imm32;
  logic [2:0]         dec_fmt;
  logic               dec_illegal;
  rec_t               dec_rec;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Every immediate fits in 32 bits; sign extension to XLEN happens once below.
  // Shamt values have bit 31 clear, so the same extension zero-extends them.
  always_comb begin
    dec_imm32   = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0010011: begin
        if ((SHAMT_MODE != 0) && is_shift) begin
          dec_fmt = FMT_SHAMT;
          if (XLEN == 64) dec_imm32 = {26'b0, in_instr[25:20]};
          else            dec_imm32 = {27'b0, in_instr[24:20]};
        end else begin
          dec_fmt   = FMT_I;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0011011: begin
        // OP-IMM-32 only exists on RV64; word shifts always take a 5-bit shamt.
        if (XLEN == 64) begin
          if ((SHAMT_MODE != 0) && is_shift) begin
            dec_fmt   = FMT_SHAMT;
            dec_imm32 = {27'b0, in_instr[24:20]};
          end else begin
            dec_fmt   = FMT_I;
            dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
          end
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    dec_rec.imm     = XLEN'(dec_imm32);
    dec_rec.fmt     = dec_fmt;
    dec_rec.illegal = dec_illegal;
    dec_rec.tag     = in_tag;
  end

  // ---------------------------------------------------------------------------
  // Elastic buffer
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  rec_t             m_q, m_d;
  rec_t             k_q, k_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = (state_q != ST_EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // Buffer contents are simply abandoned; only the state matters.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            m_d     = dec_rec;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            m_d = dec_rec;
          end else if (in_fire) begin
            k_d     = dec_rec;
            state_d = ST_TWO;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            m_d     = k_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
      if (in_fire && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Registered ready: accept next cycle unless both entries will be full.
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      m_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      m_q        <= m_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;
  assign out_tag     = m_q.tag;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Four instances share one stimulus stream:
//   0: XLEN=32, SHAMT_MODE=1, CNT_W=16
//   1: XLEN=64, SHAMT_MODE=1, CNT_W=16
//   2: XLEN=32, SHAMT_MODE=0, CNT_W=16
//   3: XLEN=32, SHAMT_MODE=1, CNT_W=2
// The handshake is identical across instances, so a single scoreboard entry
// carries the expected decode of every variant. A negedge monitor checks the
// front of the scoreboard, the handshake and the counters every cycle; the
// directed steps add explicit checks against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic [31:0] imm_a, imm_c, imm_d;
  logic [63:0] imm_b;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic [1:0]  cnt_d;

  logic [3:0][2:0]  fmt_w;
  logic [3:0]       ill_w;
  logic [3:0][31:0] tag_w;
  logic [3:0]       val_w;
  logic [3:0]       rdy_w;
  logic [3:0][63:0] imm_w;
  logic [3:0][15:0] cnt_w;

  assign imm_w[0] = {32'b0, imm_a};
  assign imm_w[1] = imm_b;
  assign imm_w[2] = {32'b0, imm_c};
  assign imm_w[3] = {32'b0, imm_d};
  assign cnt_w[0] = cnt_a;
  assign cnt_w[1] = cnt_b;
  assign cnt_w[2] = cnt_c;
  assign cnt_w[3] = {14'b0, cnt_d};

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SHAMT_MODE(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w[0]),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(val_w[0]), .out_ready(out_ready),
    .out_imm(imm_a), .out_fmt(fmt_w[0]), .out_illegal(ill_w[0]), .out_tag(tag_w[0]),
    .illegal_cnt(cnt_a));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SHAMT_MODE(1), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w[1]),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(val_w[1]), .out_ready(out_ready),
    .out_imm(imm_b), .out_fmt(fmt_w[1]), .out_illegal(ill_w[1]), .out_tag(tag_w[1]),
    .illegal_cnt(cnt_b));

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SHAMT_MODE(0), .CNT_W(16)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w[2]),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(val_w[2]), .out_ready(out_ready),
    .out_imm(imm_c), .out_fmt(fmt_w[2]), .out_illegal(ill_w[2]), .out_tag(tag_w[2]),
    .illegal_cnt(cnt_c));

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SHAMT_MODE(1), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_w[3]),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(val_w[3]), .out_ready(out_ready),
    .out_imm(imm_d), .out_fmt(fmt_w[3]), .out_illegal(ill_w[3]), .out_tag(tag_w[3]),
    .illegal_cnt(cnt_d));

  // ---------------------------------------------------------------------------
  // Reference decode and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } dec_t;

  typedef struct packed {
    logic [3:0][63:0] imm;
    logic [3:0][2:0]  fmt;
    logic [3:0]       ill;
    logic [31:0]      tag;
    logic [31:0]      instr;
  } exp_t;

  function automatic dec_t ref_dec(input logic [31:0] ins, input bit x64, input bit sh);
    dec_t        r;
    logic [63:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    logic [6:0]  op;
    bit          shf;
    op    = ins[6:0];
    shf   = (ins[14:12] == 3'b001) || (ins[14:12] == 3'b101);
    i_imm = {{52{ins[31]}}, ins[31:20]};
    s_imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    b_imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    u_imm = {{32{ins[31]}}, ins[31:12], 12'b0};
    j_imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    r = '{imm: 64'd0, fmt: 3'd0, ill: 1'b1};
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 || (op == 7'h1B && x64))
      r = '{imm: i_imm, fmt: 3'd1, ill: 1'b0};
    if (op == 7'h13 && sh && shf)
      r = '{imm: x64 ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]}, fmt: 3'd6, ill: 1'b0};
    if (op == 7'h1B && x64 && sh && shf)
      r = '{imm: {59'd0, ins[24:20]}, fmt: 3'd6, ill: 1'b0};
    if (op == 7'h23) r = '{imm: s_imm, fmt: 3'd2, ill: 1'b0};
    if (op == 7'h63) r = '{imm: b_imm, fmt: 3'd3, ill: 1'b0};
    if (op == 7'h37 || op == 7'h17) r = '{imm: u_imm, fmt: 3'd4, ill: 1'b0};
    if (op == 7'h6F) r = '{imm: j_imm, fmt: 3'd5, ill: 1'b0};
    if (!x64) r.imm = {32'd0, r.imm[31:0]};
    return r;
  endfunction

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_tx  = 0;
  bit          mon_en = 1'b0;
  int unsigned cnt_m[4] = '{0, 0, 0, 0};
  int unsigned cnt_max[4] = '{65535, 65535, 65535, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Checks sampled on the falling edge, then the model advances for the
  // rising edge that follows.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("out_valid[%0d]", i), 64'(val_w[i]), 64'(sb.size() != 0));
        chk($sformatf("in_ready[%0d]", i), 64'(rdy_w[i]), 64'(sb.size() != 2));
        chk($sformatf("illegal_cnt[%0d]", i), 64'(cnt_w[i]), 64'(cnt_m[i]));
        if (sb.size() != 0) begin
          chk($sformatf("imm[%0d]", i), imm_w[i], sb[0].imm[i]);
          chk($sformatf("fmt[%0d]", i), 64'(fmt_w[i]), 64'(sb[0].fmt[i]));
          chk($sformatf("illegal[%0d]", i), 64'(ill_w[i]), 64'(sb[0].ill[i]));
          chk($sformatf("tag[%0d]", i), 64'(tag_w[i]), 64'(sb[0].tag));
        end
      end
      if (val_w[0] && out_ready && sb.size() != 0) begin
        $display("tx %0d: instr %h tag %h imm32 %h imm64 %h fmt %0d ill %b",
                 n_tx, sb[0].instr, sb[0].tag, imm_a, imm_b, fmt_w[0], ill_w[0]);
        n_tx++;
        void'(sb.pop_front());
      end
      if (rst) begin
        sb.delete();
        for (int i = 0; i < 4; i++) cnt_m[i] = 0;
      end else if (flush) begin
        sb.delete();
      end else if (in_valid && rdy_w[0]) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
          dec_t d;
          d = ref_dec(in_instr, (i == 1), (i != 2));
          e.imm[i] = d.imm;
          e.fmt[i] = d.fmt;
          e.ill[i] = d.ill;
          if (d.ill && cnt_m[i] != cnt_max[i]) cnt_m[i]++;
        end
        e.tag   = in_tag;
        e.instr = in_instr;
        sb.push_back(e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  int unsigned tag_ctr = 32'h1000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tag_ctr;
    tag_ctr  = tag_ctr + 4;
  endtask

  task automatic send(input logic [31:0] ins);
    offer(ins);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_zero_state(input string pfx);
    for (int i = 0; i < 4; i++) begin
      chk({pfx, "_valid"}, 64'(val_w[i]), 64'd0);
      chk({pfx, "_ready"}, 64'(rdy_w[i]), 64'd1);
      chk({pfx, "_imm"}, imm_w[i], 64'd0);
      chk({pfx, "_fmt"}, 64'(fmt_w[i]), 64'd0);
      chk({pfx, "_ill"}, 64'(ill_w[i]), 64'd0);
      chk({pfx, "_tag"}, 64'(tag_w[i]), 64'd0);
      chk({pfx, "_cnt"}, 64'(cnt_w[i]), 64'd0);
    end
  endtask

  logic [6:0] ops[11] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                          7'h37, 7'h17, 7'h6F, 7'h7F, 7'h33};

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk_zero_state("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // addi x1,x0,-1 then beq -4
    send(32'hFFF00093);
    chk("addi_imm", 64'(imm_a), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(fmt_w[0]), 64'd1);
    chk("addi_ill", 64'(ill_w[0]), 64'd0);
    send(32'hFE000EE3);
    chk("beq_imm", 64'(imm_a), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(fmt_w[0]), 64'd3);
    tick();

    // Backpressure: A and B fill the buffer, C waits
    out_ready = 1'b0;
    offer(32'h123450B7);
    tick();
    offer(32'h00309093);
    tick();
    offer(32'h00500113);
    chk("bp_ready_low", 64'(rdy_w[0]), 64'd0);
    chk("bp_hold_imm", 64'(imm_a), 64'h12345000);
    chk("bp_hold_fmt", 64'(fmt_w[0]), 64'd4);
    tick();
    chk("bp_ready_low2", 64'(rdy_w[0]), 64'd0);
    chk("bp_hold_imm2", 64'(imm_a), 64'h12345000);
    out_ready = 1'b1;
    tick();
    chk("bp_b_imm", 64'(imm_a), 64'd3);
    chk("bp_b_fmt", 64'(fmt_w[0]), 64'd6);
    tick();
    in_valid = 1'b0;
    chk("bp_c_imm", 64'(imm_a), 64'd5);
    chk("bp_c_valid", 64'(val_w[0]), 64'd1);
    tick();

    // Shift-amount mode
    send(32'h00309093);
    chk("slli_imm", 64'(imm_a), 64'd3);
    chk("slli_fmt", 64'(fmt_w[0]), 64'd6);
    send(32'h4030D093);
    chk("srai_imm", 64'(imm_a), 64'd3);
    chk("srai_fmt", 64'(fmt_w[0]), 64'd6);
    chk("srai_noshamt_imm", 64'(imm_c), 64'h403);
    chk("srai_noshamt_fmt", 64'(fmt_w[2]), 64'd1);

    // RV64 formats and OP-IMM-32
    send(32'h800000B7);
    chk("lui64_imm", imm_b, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", 64'(fmt_w[1]), 64'd4);
    send(32'hFF9FF06F);
    chk("jal64_imm", imm_b, 64'hFFFFFFFFFFFFFFF8);
    chk("jal64_fmt", 64'(fmt_w[1]), 64'd5);
    send(32'h0050009B);
    chk("addiw64_ill", 64'(ill_w[1]), 64'd0);
    chk("addiw64_fmt", 64'(fmt_w[1]), 64'd1);
    chk("addiw64_imm", imm_b, 64'd5);
    chk("addiw32_ill", 64'(ill_w[0]), 64'd1);
    chk("addiw32_fmt", 64'(fmt_w[0]), 64'd0);

    // Illegal opcode counting and saturation
    repeat (3) send(32'h0000007F);
    chk("illop_ill", 64'(ill_w[1]), 64'd1);
    chk("illop_imm", imm_b, 64'd0);
    chk("illop_cnt3", 64'(cnt_b), 64'd3);
    repeat (2) send(32'h0000007F);
    chk("illop_sat_cnt", 64'(cnt_d), 64'd3);
    chk("illop_cnt5", 64'(cnt_b), 64'd5);
    chk("illop_cnt6", 64'(cnt_a), 64'd6);
    tick();

    // Flush in ONE with a same-cycle accept of an illegal opcode
    out_ready = 1'b0;
    send(32'h00100093);
    offer(32'h0000007F);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush1_valid", 64'(val_w[0]), 64'd0);
    chk("flush1_ready", 64'(rdy_w[0]), 64'd1);
    chk("flush1_cnt", 64'(cnt_b), 64'd5);

    // Flush with the buffer full
    offer(32'h00100093);
    tick();
    offer(32'h00200093);
    tick();
    chk("fill_two_ready", 64'(rdy_w[0]), 64'd0);
    offer(32'h0000007F);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush2_valid", 64'(val_w[0]), 64'd0);
    chk("flush2_ready", 64'(rdy_w[0]), 64'd1);
    chk("flush2_cnt", 64'(cnt_b), 64'd5);

    // Reset from ONE
    send(32'h800000B7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero_state("rst_one");

    // Random traffic through the scoreboard
    for (int c = 0; c < 60; c++) begin
      logic [31:0] r;
      r = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) offer({r[31:7], ops[$urandom_range(0, 10)]});
      else in_valid = 1'b0;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
